// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, arrow scan codes and frame-state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  // Arrow keys (E0-prefixed) consumed by the cursor FSM
  localparam logic [7:0] LEFT  = 8'h6B;
  localparam logic [7:0] RIGHT = 8'h74;
  localparam logic [7:0] UP    = 8'h75;
  localparam logic [7:0] DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } frame_state_e;

  // Odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus stability filter; one-cycle strobe on a filtered falling edge.
// Latency: 2 sync cycles + FILTER_LEN stable cycles; no backpressure (pure input path).
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_i,
  output logic fall_stb_o
);
  import ps2_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;
  logic             fall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      fall_q <= 1'b0;
      // Any cycle where the line agrees with the filtered level restarts the count
      if (sync_q[1] != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_q <= sync_q[1];
          cnt_q  <= '0;
          fall_q <= ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign fall_stb_o = fall_q;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 device-to-host deserialiser folding E0/F0 prefixes into one make/break event per key.
// Latency: event pulses one cycle after the filtered stop-bit edge; no backpressure.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       done_tick,
  output logic       release_tick,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic         fall_stb;
  logic [1:0]   pd_sync_q;
  logic         pd;

  frame_state_e state_q;
  logic [2:0]   bit_cnt_q;
  logic [7:0]   shreg_q;
  logic         parity_q;
  logic [TW-1:0] timer_q;
  logic         ext_f_q;
  logic         brk_f_q;
  logic [7:0]   scan_q;
  logic         ext_q;
  logic         done_q;
  logic         rel_q;
  logic         err_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk        (clk),
    .resetn     (resetn),
    .raw_i      (ps2c),
    .fall_stb_o (fall_stb)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pd_sync_q <= 2'b11;
    else         pd_sync_q <= {pd_sync_q[0], ps2d};
  end
  assign pd = pd_sync_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      timer_q   <= '0;
      ext_f_q   <= 1'b0;
      brk_f_q   <= 1'b0;
      scan_q    <= '0;
      ext_q     <= 1'b0;
      done_q    <= 1'b0;
      rel_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rel_q  <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == IDLE) begin
        if (fall_stb && !pd) begin
          state_q   <= SHIFT;
          bit_cnt_q <= '0;
          timer_q   <= '0;
        end
      end else if (fall_stb) begin
        timer_q <= '0;
        case (state_q)
          SHIFT: begin
            shreg_q   <= {pd, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= pd;
            state_q  <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (pd && odd_parity_ok(shreg_q, parity_q)) begin
              if (shreg_q == PS2_EXT_PREFIX) begin
                ext_f_q <= 1'b1;
              end else if (shreg_q == PS2_BREAK_PREFIX) begin
                brk_f_q <= 1'b1;
              end else begin
                scan_q  <= shreg_q;
                ext_q   <= ext_f_q;
                done_q  <= ~brk_f_q;
                rel_q   <= brk_f_q;
                ext_f_q <= 1'b0;
                brk_f_q <= 1'b0;
              end
            end else begin
              err_q   <= 1'b1;
              ext_f_q <= 1'b0;
              brk_f_q <= 1'b0;
            end
          end
        endcase
      end else if (timer_q == TIMER_LAST) begin
        // Stalled mid-frame: drop it along with any pending prefixes
        state_q <= IDLE;
        timer_q <= '0;
        err_q   <= 1'b1;
        ext_f_q <= 1'b0;
        brk_f_q <= 1'b0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign scan_code    = scan_q;
  assign extended     = ext_q;
  assign done_tick    = done_q;
  assign release_tick = rel_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Drives PS/2 frames (directed and random) and compares against a byte-level event model.
module tb_ps2_scan_decoder;

  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int HP = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] scan_code;
  logic       extended, done_tick, release_tick, frame_err;

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .scan_code    (scan_code),
    .extended     (extended),
    .done_tick    (done_tick),
    .release_tick (release_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  int d_cnt = 0, r_cnt = 0, e_cnt = 0, excl_viol = 0;
  int last_done_cyc = 0, stop_fall_cyc = 0;
  always @(negedge clk) begin
    if (resetn) begin
      if (done_tick) begin d_cnt++; last_done_cyc = cyc; end
      if (release_tick) r_cnt++;
      if (frame_err) e_cnt++;
      if ((done_tick && release_tick) || ((done_tick || release_tick) && frame_err))
        excl_viol++;
    end
  end

  // Byte-level reference: prefix flags and expected event counts
  bit         m_ext_f = 0, m_brk_f = 0, m_ext = 0;
  logic [7:0] m_scan = 8'h00;
  int         m_done = 0, m_rel = 0, m_err = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_err++; m_ext_f = 0; m_brk_f = 0;
    end else if (b == 8'hE0) begin
      m_ext_f = 1;
    end else if (b == 8'hF0) begin
      m_brk_f = 1;
    end else begin
      m_scan = b; m_ext = m_ext_f;
      if (m_brk_f) m_rel++; else m_done++;
      m_ext_f = 0; m_brk_f = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input bit dbit, input bit glitch, input bit is_stop);
    @(negedge clk);
    ps2d = dbit;
    wait_cyc(HP / 2);
    ps2c = 1'b0;
    if (is_stop) stop_fall_cyc = cyc;
    wait_cyc(HP);
    ps2c = 1'b1;
    if (glitch) begin
      wait_cyc(5); ps2c = 1'b0; wait_cyc(3); ps2c = 1'b1; wait_cyc(HP / 2 - 8);
    end else begin
      wait_cyc(HP / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch, i == 10);
    ps2d = 1'b1;
  endtask

  task automatic verify(input string tag, input int prev_done);
    wait_cyc(20);
    chk({tag, ".done"}, d_cnt, m_done);
    chk({tag, ".rel"}, r_cnt, m_rel);
    chk({tag, ".err"}, e_cnt, m_err);
    chk({tag, ".scan"}, scan_code, m_scan);
    chk({tag, ".ext"}, extended, m_ext);
    if (m_done != prev_done)
      chk({tag, ".latency_ok"}, (last_done_cyc - stop_fall_cyc) <= FL + 4, 1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input bit glitch);
    int prev;
    prev = m_done;
    send_frame(b, bad_par, bad_stop, glitch, 11);
    model_byte(b, !bad_par && !bad_stop);
    verify(tag, prev);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {scan_code, extended, done_tick, release_tick, frame_err}, 32'h0);
  endtask

  logic [7:0] arrows [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};

  initial begin
    logic [7:0] b;
    bit bp, bs, gl;
    wait_cyc(5);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    wait_cyc(20);

    run_frame("make_1c", 8'h1C, 0, 0, 0);
    run_frame("e0", 8'hE0, 0, 0, 0);
    run_frame("e0_75", 8'h75, 0, 0, 0);
    run_frame("brk_e0", 8'hE0, 0, 0, 0);
    run_frame("brk_f0", 8'hF0, 0, 0, 0);
    run_frame("brk_75", 8'h75, 0, 0, 0);
    run_frame("badpar_74", 8'h74, 1, 0, 0);
    run_frame("make_6b", 8'h6B, 0, 0, 0);

    send_frame(8'h72, 0, 0, 0, 5);
    wait_cyc(TO + 10);
    m_err++; m_ext_f = 0; m_brk_f = 0;
    verify("timeout", m_done);
    run_frame("after_to_72", 8'h72, 0, 0, 0);

    run_frame("glitch_1c", 8'h1C, 0, 0, 1);
    run_frame("glitch_badstop", 8'h29, 0, 1, 1);

    run_frame("rst_e0", 8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0, 6);
    @(negedge clk);
    resetn = 1'b0;
    wait_cyc(3);
    chk_reset_outputs("reset_mid");
    m_ext_f = 0; m_brk_f = 0; m_ext = 0; m_scan = 8'h00;
    resetn = 1'b1;
    wait_cyc(10);
    run_frame("post_rst_75", 8'h75, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = arrows[$urandom_range(0, 3)];
        3:       b = ($urandom_range(0, 1) == 0) ? 8'hE1 : 8'hAA;
        default: b = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
      gl = ($urandom_range(0, 3) == 0);
      run_frame("rand", b, bp, bs, gl);
    end

    chk("exclusive_pulses", excl_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
